// File: rtl/conv_ctrl.sv
// conv_ctrl: convolution loop sequencer issuing (oc, pix, ic) operands to a PE array
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_ch, out_ch,      layer configuration, latched in LOAD
//   map_size
//   conv_start          start pulse, honoured only in IDLE
//   conv_done           single-cycle completion pulse
//   out_ch_cnt          output channel currently processed
//   pe_ready            PE array accepts an operand this cycle
//   rd_en               operand issue valid
//   pix_addr, ic_idx    pixel / input-channel index of the current issue
//   acc_clr, acc_last   first / last input channel of the current pixel
//   perf_stall_cnt      RUN cycles with pe_ready low (only with CONV_CTRL_PERF_EN)
//
// Optional feature: define CONV_CTRL_PERF_EN to add the stall counter port.
module conv_ctrl #(
  parameter int PIPE_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_ch,
  input  logic [7:0]  out_ch,
  input  logic [15:0] map_size,
  input  logic        conv_start,
  output logic        conv_done,
  output logic [7:0]  out_ch_cnt,
  input  logic        pe_ready,
  output logic        rd_en,
  output logic [15:0] pix_addr,
  output logic [7:0]  ic_idx,
  output logic        acc_clr,
  output logic        acc_last
`ifdef CONV_CTRL_PERF_EN
  ,output logic [31:0] perf_stall_cnt
`endif
);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
  localparam logic [3:0] DRAIN_LAST = 4'(PIPE_LAT - 1);
  state_t      state;
  logic [7:0]  in_ch_q, out_ch_q;
  logic [15:0] map_q;
  logic [3:0]  dcnt;
  logic        ic_end, pix_end, oc_end;
  // latched values are nonzero whenever these are used, so the -1 never wraps
  assign ic_end  = ic_idx == in_ch_q - 8'd1;
  assign pix_end = pix_addr == map_q - 16'd1;
  assign oc_end  = out_ch_cnt == out_ch_q - 8'd1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ch_q    <= '0;
      out_ch_q   <= '0;
      map_q      <= '0;
      dcnt       <= '0;
      conv_done  <= 1'b0;
      rd_en      <= 1'b0;
      acc_clr    <= 1'b0;
      acc_last   <= 1'b0;
      pix_addr   <= '0;
      ic_idx     <= '0;
      out_ch_cnt <= '0;
`ifdef CONV_CTRL_PERF_EN
      perf_stall_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (conv_start) state <= LOAD;
        LOAD: begin
          in_ch_q    <= in_ch;
          out_ch_q   <= out_ch;
          map_q      <= map_size;
          pix_addr   <= '0;
          ic_idx     <= '0;
          out_ch_cnt <= '0;
          dcnt       <= '0;
`ifdef CONV_CTRL_PERF_EN
          perf_stall_cnt <= '0;
`endif
          if (in_ch == 8'd0 || out_ch == 8'd0 || map_size == 16'd0) begin
            state     <= DONE;
            conv_done <= 1'b1;
          end else begin
            state    <= RUN;
            rd_en    <= 1'b1;
            acc_clr  <= 1'b1;
            acc_last <= in_ch == 8'd1;
          end
        end
        RUN: begin
`ifdef CONV_CTRL_PERF_EN
          if (!pe_ready) perf_stall_cnt <= perf_stall_cnt + {31'd0, perf_stall_cnt != '1};
`endif
          if (pe_ready) begin
            if (ic_end) begin
              ic_idx   <= '0;
              acc_clr  <= !pix_end;
              acc_last <= !pix_end && in_ch_q == 8'd1;
              if (pix_end) begin
                state <= DRAIN;
                rd_en <= 1'b0;
                dcnt  <= '0;
              end else begin
                pix_addr <= pix_addr + 16'd1;
              end
            end else begin
              ic_idx   <= ic_idx + 8'd1;
              acc_clr  <= 1'b0;
              acc_last <= ic_idx + 8'd1 == in_ch_q - 8'd1;
            end
          end
        end
        DRAIN: begin
          dcnt <= dcnt + 4'd1;
          if (dcnt == DRAIN_LAST) begin
            if (oc_end) begin
              state     <= DONE;
              conv_done <= 1'b1;
            end else begin
              state      <= RUN;
              out_ch_cnt <= out_ch_cnt + 8'd1;
              pix_addr   <= '0;
              ic_idx     <= '0;
              rd_en      <= 1'b1;
              acc_clr    <= 1'b1;
              acc_last   <= in_ch_q == 8'd1;
            end
          end
        end
        DONE: begin
          conv_done <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_ctrl.sv
// tb_conv_ctrl: randomized and directed checks of conv_ctrl against a loop-nest reference model
module tb_conv_ctrl;
  localparam int P = 4;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_ch, out_ch;
  logic [15:0] map_size;
  logic        conv_start, pe_ready;
  logic        conv_done, rd_en, acc_clr, acc_last;
  logic [7:0]  out_ch_cnt, ic_idx;
  logic [15:0] pix_addr;
`ifdef CONV_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif
  int checks = 0;
  int errors = 0;
  int dc;

  conv_ctrl #(.PIPE_LAT(P)) dut (
    .clk(clk), .rst_n(rst_n), .in_ch(in_ch), .out_ch(out_ch), .map_size(map_size),
    .conv_start(conv_start), .conv_done(conv_done), .out_ch_cnt(out_ch_cnt),
    .pe_ready(pe_ready), .rd_en(rd_en), .pix_addr(pix_addr), .ic_idx(ic_idx),
    .acc_clr(acc_clr), .acc_last(acc_last)
`ifdef CONV_CTRL_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one convolution. The model is the plain loop nest oc > pix > ic; timing follows
  // the rules: first issue at T+2, next channel PIPE_LAT+1 cycles after the last accepted
  // issue of the previous one, done PIPE_LAT+1 cycles after the final accepted issue.
  task automatic run(input int ni, input int no, input int nm, input int sa, input int sl,
                     input int rs, input bit rnd, output int done_c);
    int ep[$], ei[$], eo[$];
    int idx = 0, nxt = 2, dcyc, stalls = 0, total, budget;
    bit zero, pe, exp_rd;
    zero = (ni == 0 || no == 0 || nm == 0);
    if (!zero)
      for (int o = 0; o < no; o++)
        for (int p = 0; p < nm; p++)
          for (int i = 0; i < ni; i++) begin
            eo.push_back(o); ep.push_back(p); ei.push_back(i);
          end
    total = ep.size();
    dcyc = zero ? 2 : 1000000;
    budget = 4 * total + no * (P + 2) + 20;
    done_c = -1;
    @(negedge clk);
    in_ch = 8'(ni); out_ch = 8'(no); map_size = 16'(nm);
    conv_start = 1'b1; pe_ready = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      conv_start = (c == rs);
      if (c >= 2) begin
        in_ch = 8'($urandom); out_ch = 8'($urandom); map_size = 16'($urandom);
      end
      exp_rd = idx < total && c >= nxt;
      chk("rd_en", rd_en, exp_rd);
      if (rd_en && idx < total) begin
        chk("pix_addr", pix_addr, ep[idx]);
        chk("ic_idx", ic_idx, ei[idx]);
        chk("out_ch_cnt", out_ch_cnt, eo[idx]);
        chk("acc_clr", acc_clr, ei[idx] == 0);
        chk("acc_last", acc_last, ei[idx] == ni - 1);
      end
      if (conv_done === 1'b1 && done_c < 0) done_c = c;
      chk("conv_done", conv_done, c == dcyc);
      pe = !(c >= sa && c < sa + sl) && (!rnd || $urandom_range(3) != 0);
      pe_ready = pe;
      if (rd_en && !pe) stalls++;
      if (rd_en && pe && idx < total) begin
        idx++;
        if (idx == total) dcyc = c + P + 1;
        else if (eo[idx] != eo[idx-1]) nxt = c + P + 1;
      end
      if (c == dcyc + 2) break;
    end
    chk("done_cycle", done_c, dcyc);
    chk("issues", idx, total);
    chk("final_oc", out_ch_cnt, zero ? 0 : no - 1);
`ifdef CONV_CTRL_PERF_EN
    chk("perf_stall_cnt", perf_stall_cnt, stalls);
`endif
    pe_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; conv_start = 1'b0; pe_ready = 1'b0;
    in_ch = '0; out_ch = '0; map_size = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_conv_done", conv_done, 0);
    chk("rst_acc", {acc_clr, acc_last}, 0);
    chk("rst_idx", {pix_addr, ic_idx, out_ch_cnt}, 0);
`ifdef CONV_CTRL_PERF_EN
    chk("rst_perf", perf_stall_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(2, 1, 3, 0, 0, 0, 0, dc);  chk("basic_done_T12", dc, 12);
    run(2, 1, 3, 3, 3, 0, 0, dc);  chk("stall_done_T15", dc, 15);
    run(1, 3, 2, 0, 0, 0, 0, dc);  chk("multi_oc_done_T20", dc, 20);
    run(5, 2, 0, 0, 0, 0, 0, dc);  chk("zero_map_done_T2", dc, 2);
    run(0, 1, 1, 0, 0, 0, 0, dc);  chk("zero_ic_done_T2", dc, 2);
    run(1, 0, 1, 0, 0, 0, 0, dc);  chk("zero_oc_done_T2", dc, 2);
    run(2, 1, 3, 0, 0, 4, 0, dc);  chk("restart_ignored_T12", dc, 12);
    run(255, 1, 1, 0, 0, 0, 1, dc);
    for (int k = 0; k < 20; k++)
      run($urandom_range(1, 4), $urandom_range(1, 3), $urandom_range(1, 5), 0, 0, 0, 1, dc);
    // reset in the middle of a run
    @(negedge clk);
    in_ch = 8'd2; out_ch = 8'd2; map_size = 16'd4; conv_start = 1'b1; pe_ready = 1'b1;
    @(negedge clk);
    conv_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rd_en", rd_en, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_rd_en", rd_en, 0);
    chk("abort_idx", {pix_addr, ic_idx, out_ch_cnt}, 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", conv_done, 0);
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("idle_after_rst", {rd_en, conv_done}, 0);
    end
    run(2, 2, 3, 0, 0, 0, 1, dc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
